// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller: opcodes, ALUOp,
// operand/PC select codes, FSM state type and the datapath control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_RST, FETCH, DECODE, MEM_ADR, MEM_RD, MEM_WB, MEM_WR,
        R_EXEC, R_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_beq;
        logic       pc_write_bne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_supported(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_BNE) || (op == OP_J) || (op == OP_ADDI);
    endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational map from controller state to the datapath control word.
// Only FETCH/MEM_WR outputs depend on mem_ready; opcode is looked at only in DECODE.
module mc_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  state_t      state_i,
    input  logic [5:0]  opcode_i,
    input  logic        branch_ne_i,
    input  logic        mem_ready_i,
    output ctrl_t       ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
            end
            DECODE: begin
                ctrl_o.alu_src_b = SRCB_IMM_SH;
                if (!op_supported(opcode_i)) begin
                    ctrl_o.illegal_op = 1'b1;
                    ctrl_o.instr_done = 1'b1;
                end
            end
            MEM_ADR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            MEM_WR: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.i_or_d     = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            R_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_REG;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            R_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl_o.alu_src_a    = 1'b1;
                ctrl_o.alu_src_b    = SRCB_REG;
                ctrl_o.alu_op       = ALUOP_SUB;
                ctrl_o.pc_source    = PCSRC_ALUOUT;
                ctrl_o.instr_done   = 1'b1;
                ctrl_o.pc_write_beq = !branch_ne_i;
                ctrl_o.pc_write_bne = branch_ne_i;
            end
            JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            ADDI_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            ADDI_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: holds the state register
// and next-state logic; the control word comes from mc_ctrl_decode.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int USE_MEM_READY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_beq,
    output logic       pc_write_bne,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic       instr_done,
    output logic       illegal_op
);

    state_t state_q, state_d;
    logic   branch_ne_q, branch_ne_d;
    logic   mem_rdy;
    ctrl_t  ctrl;

    assign mem_rdy = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

    always_comb begin
        state_d     = state_q;
        branch_ne_d = branch_ne_q;
        case (state_q)
            S_RST:   state_d = FETCH;
            FETCH:   state_d = mem_rdy ? DECODE : FETCH;
            DECODE: begin
                // Remember beq/bne here so BRANCH never has to look at the opcode.
                branch_ne_d = (opcode == OP_BNE);
                case (opcode)
                    OP_LW, OP_SW:   state_d = MEM_ADR;
                    OP_RTYPE:       state_d = R_EXEC;
                    OP_BEQ, OP_BNE: state_d = BRANCH;
                    OP_J:           state_d = JUMP;
                    OP_ADDI:        state_d = ADDI_EXEC;
                    default:        state_d = FETCH;
                endcase
            end
            MEM_ADR:   state_d = (opcode == OP_LW) ? MEM_RD : MEM_WR;
            MEM_RD:    state_d = mem_rdy ? MEM_WB : MEM_RD;
            MEM_WB:    state_d = FETCH;
            MEM_WR:    state_d = mem_rdy ? FETCH : MEM_WR;
            R_EXEC:    state_d = R_WB;
            R_WB:      state_d = FETCH;
            BRANCH:    state_d = FETCH;
            JUMP:      state_d = FETCH;
            ADDI_EXEC: state_d = ADDI_WB;
            ADDI_WB:   state_d = FETCH;
            default:   state_d = S_RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_RST;
            branch_ne_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            branch_ne_q <= branch_ne_d;
        end
    end

    mc_ctrl_decode u_decode (
        .state_i     (state_q),
        .opcode_i    (opcode),
        .branch_ne_i (branch_ne_q),
        .mem_ready_i (mem_rdy),
        .ctrl_o      (ctrl)
    );

    assign pc_write     = ctrl.pc_write;
    assign pc_write_beq = ctrl.pc_write_beq;
    assign pc_write_bne = ctrl.pc_write_bne;
    assign i_or_d       = ctrl.i_or_d;
    assign mem_read     = ctrl.mem_read;
    assign mem_write    = ctrl.mem_write;
    assign ir_write     = ctrl.ir_write;
    assign mem_to_reg   = ctrl.mem_to_reg;
    assign reg_dst      = ctrl.reg_dst;
    assign reg_write    = ctrl.reg_write;
    assign alu_src_a    = ctrl.alu_src_a;
    assign alu_src_b    = ctrl.alu_src_b;
    assign pc_source    = ctrl.pc_source;
    assign alu_op       = ctrl.alu_op;
    assign instr_done   = ctrl.instr_done;
    assign illegal_op   = ctrl.illegal_op;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: per-instruction expected control
// sequences and latencies, directed cases plus randomized opcode/stall streams.
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011,
                           T_BEQ = 6'b000100, T_BNE = 6'b000101, T_J = 6'b000010,
                           T_ADDI = 6'b001000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       mem_ready = 1'b0;
    logic       mem_ready0 = 1'b0;
    logic [5:0] opcode = 6'd0;

    int vectors = 0;
    int miscompares = 0;

    logic       a_pcw, a_beq, a_bne, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw, a_asa, a_done, a_ill;
    logic [1:0] a_asb, a_psrc, a_aop;
    logic       b_pcw, b_beq, b_bne, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw, b_asa, b_done, b_ill;
    logic [1:0] b_asb, b_psrc, b_aop;

    mips_multicycle_ctrl #(.USE_MEM_READY(1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(a_pcw), .pc_write_beq(a_beq), .pc_write_bne(a_bne), .i_or_d(a_iord),
        .mem_read(a_mrd), .mem_write(a_mwr), .ir_write(a_irw), .mem_to_reg(a_m2r),
        .reg_dst(a_rdst), .reg_write(a_rw), .alu_src_a(a_asa), .alu_src_b(a_asb),
        .pc_source(a_psrc), .alu_op(a_aop), .instr_done(a_done), .illegal_op(a_ill)
    );

    mips_multicycle_ctrl #(.USE_MEM_READY(0)) dut_nr (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready0),
        .pc_write(b_pcw), .pc_write_beq(b_beq), .pc_write_bne(b_bne), .i_or_d(b_iord),
        .mem_read(b_mrd), .mem_write(b_mwr), .ir_write(b_irw), .mem_to_reg(b_m2r),
        .reg_dst(b_rdst), .reg_write(b_rw), .alu_src_a(b_asa), .alu_src_b(b_asb),
        .pc_source(b_psrc), .alu_op(b_aop), .instr_done(b_done), .illegal_op(b_ill)
    );

    logic [18:0] obs_a, obs_b;
    assign obs_a = {a_pcw, a_beq, a_bne, a_iord, a_mrd, a_mwr, a_irw, a_m2r, a_rdst, a_rw,
                    a_asa, a_asb, a_psrc, a_aop, a_done, a_ill};
    assign obs_b = {b_pcw, b_beq, b_bne, b_iord, b_mrd, b_mwr, b_irw, b_m2r, b_rdst, b_rw,
                    b_asa, b_asb, b_psrc, b_aop, b_done, b_ill};

    // Control word in port order: pcw beq bne iord mrd mwr irw m2r rdst rw asa asb psrc aop done ill
    function automatic logic [18:0] cw(input logic pcw, beq, bne, iord, mrd, mwr, irw, m2r,
                                       rdst, rw, asa, input logic [1:0] asb, psrc, aop,
                                       input logic done, ill);
        return {pcw, beq, bne, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, psrc, aop, done, ill};
    endfunction

    function automatic logic [18:0] w_fetch(input logic r);
        return cw(r,0,0,0,1,0,r,0,0,0,0, 2'b01, 2'b00, 2'b00, 0,0);
    endfunction
    function automatic logic [18:0] w_decode(input logic ill);
        return cw(0,0,0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, ill, ill);
    endfunction
    function automatic logic [18:0] w_addr();   return cw(0,0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0); endfunction
    function automatic logic [18:0] w_memrd();  return cw(0,0,0,1,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0,0); endfunction
    function automatic logic [18:0] w_memwb();  return cw(0,0,0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 1,0); endfunction
    function automatic logic [18:0] w_memwr(input logic r);
        return cw(0,0,0,1,0,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, r,0);
    endfunction
    function automatic logic [18:0] w_rexec();  return cw(0,0,0,0,0,0,0,0,0,0,1, 2'b00, 2'b00, 2'b10, 0,0); endfunction
    function automatic logic [18:0] w_rwb();    return cw(0,0,0,0,0,0,0,0,1,1,0, 2'b00, 2'b00, 2'b00, 1,0); endfunction
    function automatic logic [18:0] w_branch(input logic ne);
        return cw(0,!ne,ne,0,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 1,0);
    endfunction
    function automatic logic [18:0] w_jump();   return cw(1,0,0,0,0,0,0,0,0,0,0, 2'b00, 2'b10, 2'b00, 1,0); endfunction
    function automatic logic [18:0] w_aexec();  return cw(0,0,0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0,0); endfunction
    function automatic logic [18:0] w_awb();    return cw(0,0,0,0,0,0,0,0,0,1,0, 2'b00, 2'b00, 2'b00, 1,0); endfunction

    function automatic bit legal(input logic [5:0] op);
        return op inside {T_R, T_LW, T_SW, T_BEQ, T_BNE, T_J, T_ADDI};
    endfunction

    // Cycles from first FETCH cycle through the instr_done cycle, stalls included.
    function automatic int exp_latency(input logic [5:0] op, input int fs, input int ms);
        int base;
        case (op)
            T_LW:                base = 5 + ms;
            T_SW:                base = 4 + ms;
            T_R, T_ADDI:         base = 4;
            T_BEQ, T_BNE, T_J:   base = 3;
            default:             base = 2;
        endcase
        return base + fs;
    endfunction

    // One clock cycle: drive inputs after the falling edge, compare 1 ns later.
    task automatic step(input bit sel, input logic rst, input logic rdy, input logic [5:0] op,
                        input logic [18:0] exp, input string tag, output logic [18:0] got);
        @(negedge clk);
        reset = rst;
        mem_ready = rdy;
        opcode = op;
        #1;
        got = sel ? obs_a : obs_b;
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic reset_seq(input bit sel, input int n);
        logic [18:0] got;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < n - 1; i++) step(sel, 1'b1, 1'($urandom), opcode, '0, "reset_hold", got);
        step(sel, 1'b0, 1'($urandom), opcode, '0, "reset_release", got);
    endtask

    typedef struct { logic rdy; logic [18:0] w; } cyc_t;

    // sel=1 checks the mem_ready-honouring instance, sel=0 the one that ignores it.
    task automatic run_instr(input bit sel, input logic [5:0] op, input int fs, input int ms,
                             input string tag);
        cyc_t q[$];
        logic [18:0] got;
        int lat;
        bit seen;
        logic r;
        for (int i = 0; i <= fs; i++) begin
            r = (i == fs);
            q.push_back('{r, w_fetch(sel ? r : 1'b1)});
        end
        q.push_back('{1'($urandom), w_decode(!legal(op))});
        case (op)
            T_LW: begin
                q.push_back('{1'($urandom), w_addr()});
                for (int i = 0; i <= ms; i++) q.push_back('{(i == ms), w_memrd()});
                q.push_back('{1'($urandom), w_memwb()});
            end
            T_SW: begin
                q.push_back('{1'($urandom), w_addr()});
                for (int i = 0; i <= ms; i++) begin
                    r = (i == ms);
                    q.push_back('{r, w_memwr(sel ? r : 1'b1)});
                end
            end
            T_R: begin
                q.push_back('{1'($urandom), w_rexec()});
                q.push_back('{1'($urandom), w_rwb()});
            end
            T_BEQ, T_BNE: q.push_back('{1'($urandom), w_branch(op == T_BNE)});
            T_J:          q.push_back('{1'($urandom), w_jump()});
            T_ADDI: begin
                q.push_back('{1'($urandom), w_aexec()});
                q.push_back('{1'($urandom), w_awb()});
            end
            default: ;
        endcase
        lat = 0;
        seen = 0;
        foreach (q[k]) begin
            step(sel, 1'b0, q[k].rdy, op, q[k].w, tag, got);
            if (!seen) lat++;
            if (got[1] === 1'b1) seen = 1;
        end
        vectors++;
        assert (seen && lat == exp_latency(op, fs, ms)) else begin
            miscompares++;
            $error("FAIL %s_latency observed=%0d(done_seen=%0d) expected=%0d", tag, lat, seen,
                   exp_latency(op, fs, ms));
        end
    endtask

    initial begin
        logic [18:0] got;
        logic [5:0] ops [7];
        logic [5:0] op;
        int fs, ms;
        ops = '{T_R, T_LW, T_SW, T_BEQ, T_BNE, T_J, T_ADDI};

        reset_seq(1, 3);

        run_instr(1, T_R,    0, 0, "add");
        run_instr(1, T_LW,   0, 0, "lw");
        run_instr(1, T_SW,   0, 0, "sw");
        run_instr(1, T_BEQ,  0, 0, "beq");
        run_instr(1, T_J,    0, 0, "j");
        run_instr(1, T_ADDI, 0, 0, "addi");

        run_instr(1, T_LW, 2, 3, "lw_stall");
        run_instr(1, T_BEQ, 0, 0, "beq2");
        run_instr(1, T_BNE, 0, 0, "bne");
        run_instr(1, 6'b111111, 0, 0, "illegal");
        run_instr(1, T_SW, 1, 2, "sw_stall");

        // Reset lands while lw is stalled in its memory read.
        step(1, 1'b0, 1'b1, T_LW, w_fetch(1), "abort_fetch", got);
        step(1, 1'b0, 1'b0, T_LW, w_decode(0), "abort_decode", got);
        step(1, 1'b0, 1'b0, T_LW, w_addr(), "abort_addr", got);
        step(1, 1'b0, 1'b0, T_LW, w_memrd(), "abort_memrd", got);
        step(1, 1'b1, 1'b0, T_LW, w_memrd(), "abort_memrd_rst", got);
        step(1, 1'b1, 1'b1, T_LW, '0, "abort_rst1", got);
        step(1, 1'b1, 1'b1, T_LW, '0, "abort_rst2", got);
        step(1, 1'b0, 1'b1, T_LW, '0, "abort_rst3", got);
        run_instr(1, T_ADDI, 0, 0, "after_abort");

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom); while (legal(op));
            end else begin
                op = ops[$urandom_range(0, 6)];
            end
            fs = $urandom_range(0, 3);
            ms = $urandom_range(0, 3);
            run_instr(1, op, fs, ms, "rand");
        end

        reset_seq(0, 3);
        run_instr(0, T_SW, 0, 0, "nr_sw");
        run_instr(0, T_LW, 0, 0, "nr_lw");
        for (int n = 0; n < 10; n++) begin
            op = ops[$urandom_range(0, 6)];
            run_instr(0, op, 0, 0, "nr_rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
